md_sched: RTL
=============

// Module: md_sched
// PURPOSE
//  Multi-cycle multiply/divide sequencer owning HI/LO for the 5-stage pipeline.
//  Accepts one MD op per cycle from E stage and models fixed mult/div latency with a down-counter.
//  Drives a D-stage stall while a HI/LO-touching instruction in D would observe an unfinished op.
//  Sits beside the ALU in E; the hazard unit ORs md_stall into the global stall.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  clr       in   1   asynchronous, active-low reset
//  start     in   1   E-stage instr is a valid MD op this cycle
//  mdop      in   3   `md_mult,`md_multu,`md_div,`md_divu,`md_mthi,`md_mtlo
//  a         in   32  forwarded rs value (E stage)
//  b         in   32  forwarded rt value (E stage)
//  hilo_d    in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//  busy      out  1   long op in flight
//  md_stall  out  1   stall request to D stage
//  hi        out  32  architectural HI
//  lo        out  32  architectural LO
// BEHAVIOUR
//  - Reset (clr=0, async): state IDLE, cnt=0, hi=lo=0, busy=0, pending ops discarded.
//  - States: IDLE, BUSY. cnt is 4 bits, sized to max(MULT_CYCLES,DIV_CYCLES).
//  - IDLE & start & mult/div at edge t: latch a,b,mdop; cnt<=N (MULT_/DIV_CYCLES); -> BUSY.
//  - BUSY: cnt decrements each edge; at the edge where cnt==1, hi/lo commit, -> IDLE.
//    busy is high for exactly N cycles after edge t; new hi/lo are visible in cycle t+N+1.
//  - mthi/mtlo with start in IDLE: hi<=a or lo<=a at the next edge; never sets busy.
//  - start in BUSY: ignored; the hazard unit guarantees this by stalling. The bench asserts it never happens.
//  - md_stall = hilo_d & (busy | (start & mdop is mult/div/mthi/mtlo)). The term is combinational.
//  - Arithmetic: mult {hi,lo}=$signed(a)*$signed(b); multu unsigned 64-bit.
//    div: lo=quotient, hi=remainder, truncated toward zero, remainder sign = dividend sign.
//    divu is unsigned. Results are computed from latched operands, not live a/b.
//  - Divide by zero: lo=32'hffffffff, hi=latched a. No trap.
//  - div 0x80000000 / -1: lo=0x80000000, hi=0.
//  - Reset mid-BUSY: op aborted, hi/lo=0; a later start is accepted normally.
//  - Outputs hi/lo hold across BUSY; mfhi/mflo read them only when not stalled.
// STRUCTURE
//  - head.v gains the `md_* opcodes and the state encodings `md_idle/`md_busy.
//  - The control decoder emits mdop from the head.v constants.
//  - Single module, no sub-modules. Datapath instantiates it in E.
//  - hi/lo feed the E-stage "other" mux for mfhi/mflo.
// TESTING
//  1. mult a=-3 b=7, hilo_d=0 -> busy high 5 cycles, then hi=ffffffff lo=ffffffeb.
//  2. divu a=100 b=7, then mflo in D next cycle -> md_stall high 10 cycles, then lo=14 hi=2.
//  3. div a=-7 b=2 -> lo=fffffffd hi=ffffffff. div a=5 b=0 -> lo=ffffffff hi=5.
//  4. mthi a=12345678 while IDLE -> hi=12345678 after 1 edge, busy never asserts. mtlo symmetric.
//  5. clr low at cycle 3 of a div -> hi=lo=0, busy=0 at once. Following multu 2x3 -> lo=6 hi=0.
//  6. multu ffffffff*ffffffff -> hi=fffffffe lo=00000001. a/b change mid-BUSY -> result unchanged.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared types and result arithmetic for the multiply/divide sequencer.
package md_sched_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_hilo_t;

  // Multi-cycle ops occupy encodings 0..3.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic md_is_mt(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  // HI/LO result of a mult/div on latched operands; div corner cases never trap.
  function automatic md_hilo_t md_compute(input md_op_e op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    md_hilo_t               res;
    logic signed [2*XLEN-1:0] sp;
    logic [2*XLEN-1:0]      up;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    res = '0;
    sa  = $signed(a);
    sb  = $signed(b);
    sp  = '0;
    up  = '0;
    case (op)
      MD_MULT: begin
        sp = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
        res.hi = sp[2*XLEN-1:XLEN];
        res.lo = sp[XLEN-1:0];
      end
      MD_MULTU: begin
        up = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        res.hi = up[2*XLEN-1:XLEN];
        res.lo = up[XLEN-1:0];
      end
      MD_DIV: begin
        if (b == '0) begin
          res.lo = '1;
          res.hi = a;
        end else if ((a == 32'h8000_0000) && (b == 32'hffff_ffff)) begin
          res.lo = a;
          res.hi = '0;
        end else begin
          res.lo = $unsigned(sa / sb);
          res.hi = $unsigned(sa % sb);
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          res.lo = '1;
          res.hi = a;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, with D-stage stall request.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [2:0]      mdop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hilo_d,
  output logic            busy,
  output logic            md_stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  md_op_e           op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic             load_op;
  logic             commit;
  logic             mt_we;
  md_hilo_t         result;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= MD_IDLE;
    else      state_q <= state_d;
  end

  // Next state: long ops enter BUSY from IDLE, leave on the last count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start && md_is_long(mdop)) state_d = MD_BUSY;
      MD_BUSY: if (cnt_q == CNT_W'(1))        state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Control strobes; starts while BUSY are dropped.
  always_comb begin
    load_op = 1'b0;
    commit  = 1'b0;
    mt_we   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        load_op = start && md_is_long(mdop);
        mt_we   = start && md_is_mt(mdop);
      end
      MD_BUSY: commit = (cnt_q == CNT_W'(1));
      default: ;
    endcase
  end

  assign result = md_compute(op_q, a_q, b_q);

  // Operand latch, latency counter and architectural HI/LO.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
      op_q  <= MD_MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (load_op) begin
        op_q  <= md_op_e'(mdop);
        a_q   <= a;
        b_q   <= b;
        cnt_q <= (mdop[1]) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (state_q == MD_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        hi <= result.hi;
        lo <= result.lo;
      end else if (mt_we) begin
        if (mdop == MD_MTHI) hi <= a;
        else                 lo <= a;
      end
    end
  end

  assign busy = (state_q == MD_BUSY);

  // Stall D while it would read HI/LO ahead of an in-flight or just-issued write.
  assign md_stall = hilo_d && (busy || (start && (md_is_long(mdop) || md_is_mt(mdop))));

endmodule
